max7219_scheduler: RTL and testbench

Shares one MAX7219 serial-write engine (the block with the `addr_in`/`din`/`start`/`busy` interface) between a configuration requester and a digit-update requester. After reset it autonomously runs the chip power-up sequence. It then arbitrates between the two requesters and expands each granted request into a burst of register writes, one write per `start`/`busy` handshake. It sits between the display front-end logic and the serializer.

---
 rtl/max7219_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_max7219_scheduler.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/max7219_scheduler.sv
// max7219_scheduler: shares one MAX7219 serial-write engine between a
// configuration requester and a digit-update requester. It runs the chip
// power-up list after reset, then arbitrates and expands each granted
// request into a burst of register writes, one per start/busy handshake.
module max7219_scheduler #(
  parameter logic [3:0] INTENSITY_DEFAULT = 4'h8,
  parameter logic [2:0] SCAN_LIMIT        = 3'd7
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cfg_req,
  input  logic [7:0]  cfg_decode,
  input  logic [3:0]  cfg_intensity,
  output logic        cfg_ack,
  input  logic        upd_req,
  input  logic [31:0] upd_num,
  input  logic [2:0]  upd_dp,
  output logic        upd_ack,
  output logic [7:0]  ser_addr,
  output logic [7:0]  ser_data,
  output logic        ser_start,
  input  logic        ser_busy,
  output logic        init_done,
  output logic        busy
);

  localparam logic [2:0] ST_INIT    = 3'd0;
  localparam logic [2:0] ST_IDLE    = 3'd1;
  localparam logic [2:0] ST_ISSUE   = 3'd2;
  localparam logic [2:0] ST_WAIT_HI = 3'd3;
  localparam logic [2:0] ST_WAIT_LO = 3'd4;

  localparam logic [1:0] MODE_INIT = 2'd0;
  localparam logic [1:0] MODE_CFG  = 2'd1;
  localparam logic [1:0] MODE_UPD  = 2'd2;

  logic [2:0]  state_reg;
  logic [1:0]  mode_reg;
  logic [3:0]  step_reg;
  logic [7:0]  addr_reg;
  logic [7:0]  data_reg;
  logic        cfg_ack_reg;
  logic        upd_ack_reg;
  logic        init_done_reg;
  logic        last_grant_cfg_reg;
  logic [3:0]  cfg_intensity_reg;
  logic [31:0] upd_num_reg;
  logic [2:0]  upd_dp_reg;

  logic [3:0]  step_next;
  logic [7:0]  addr_next;
  logic [7:0]  data_next;
  logic [3:0]  last_step;
  logic        grant_cfg;
  logic        grant_upd;
  logic [7:0]  upd_byte [8];

  // One data byte per digit from the captured payload; the decimal point
  // lands on the digit selected by upd_dp.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_digit
      assign upd_byte[gi] = {(upd_dp_reg == 3'(gi)), 3'b000, upd_num_reg[4*gi +: 4]};
    end
  endgenerate

  // Tie goes to whichever requester was not served last.
  assign grant_cfg = cfg_req && (!upd_req || !last_grant_cfg_reg);
  assign grant_upd = upd_req && !grant_cfg;

  // The strobe is gated by ser_busy so ISSUE simply waits while the serializer is occupied.
  assign ser_start = (state_reg == ST_ISSUE) && !ser_busy;
  assign ser_addr  = addr_reg;
  assign ser_data  = data_reg;
  assign cfg_ack   = cfg_ack_reg;
  assign upd_ack   = upd_ack_reg;
  assign init_done = init_done_reg;
  assign busy      = (state_reg != ST_IDLE);

  // Address/data of the upcoming write; INIT loads step 0, WAIT_LO loads the following step.
  always_comb begin
    step_next = (state_reg == ST_INIT) ? step_reg : step_reg + 4'd1;
    addr_next = 8'h00;
    data_next = 8'h00;
    last_step = 4'd12;
    case (mode_reg)
      MODE_CFG: begin
        last_step = 4'd1;
        addr_next = 8'h0A;
        data_next = {4'b0000, cfg_intensity_reg};
      end
      MODE_UPD: begin
        last_step = 4'd7;
        addr_next = {4'b0000, step_next + 4'd1};
        data_next = upd_byte[step_next[2:0]];
      end
      default: begin
        case (step_next)
          4'd0:    begin addr_next = 8'h0F; data_next = 8'h00; end
          4'd1:    begin addr_next = 8'h0C; data_next = 8'h01; end
          4'd2:    begin addr_next = 8'h0B; data_next = {5'b00000, SCAN_LIMIT}; end
          4'd3:    begin addr_next = 8'h09; data_next = 8'hFF; end
          4'd4:    begin addr_next = 8'h0A; data_next = {4'b0000, INTENSITY_DEFAULT}; end
          default: begin addr_next = {4'b0000, step_next - 4'd4}; data_next = 8'h00; end
        endcase
      end
    endcase
  end

  // Sequencer: init list, arbitration with payload capture, and the per-write handshake.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg          <= ST_INIT;
      mode_reg           <= MODE_INIT;
      step_reg           <= 4'd0;
      addr_reg           <= 8'h00;
      data_reg           <= 8'h00;
      cfg_ack_reg        <= 1'b0;
      upd_ack_reg        <= 1'b0;
      init_done_reg      <= 1'b0;
      last_grant_cfg_reg <= 1'b0;
      cfg_intensity_reg  <= 4'h0;
      upd_num_reg        <= 32'h0;
      upd_dp_reg         <= 3'd0;
    end else begin
      cfg_ack_reg <= 1'b0;
      upd_ack_reg <= 1'b0;
      case (state_reg)
        ST_INIT: begin
          addr_reg  <= addr_next;
          data_reg  <= data_next;
          state_reg <= ST_ISSUE;
        end
        ST_IDLE: begin
          // First write of a burst comes straight from the requester inputs,
          // so the strobe can go out in the same cycle as the ack.
          if (grant_cfg) begin
            mode_reg           <= MODE_CFG;
            step_reg           <= 4'd0;
            cfg_intensity_reg  <= cfg_intensity;
            cfg_ack_reg        <= 1'b1;
            last_grant_cfg_reg <= 1'b1;
            addr_reg           <= 8'h09;
            data_reg           <= cfg_decode;
            state_reg          <= ST_ISSUE;
          end else if (grant_upd) begin
            mode_reg           <= MODE_UPD;
            step_reg           <= 4'd0;
            upd_num_reg        <= upd_num;
            upd_dp_reg         <= upd_dp;
            upd_ack_reg        <= 1'b1;
            last_grant_cfg_reg <= 1'b0;
            addr_reg           <= 8'h01;
            data_reg           <= {(upd_dp == 3'd0), 3'b000, upd_num[3:0]};
            state_reg          <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!ser_busy) state_reg <= ST_WAIT_HI;
        end
        ST_WAIT_HI: begin
          if (ser_busy) state_reg <= ST_WAIT_LO;
        end
        ST_WAIT_LO: begin
          if (!ser_busy) begin
            if (step_reg == last_step) begin
              state_reg <= ST_IDLE;
              if (mode_reg == MODE_INIT) init_done_reg <= 1'b1;
            end else begin
              step_reg  <= step_next;
              addr_reg  <= addr_next;
              data_reg  <= data_next;
              state_reg <= ST_ISSUE;
            end
          end
        end
        default: state_reg <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_max7219_scheduler.sv
// Directed testbench for max7219_scheduler with a 3-cycle serializer model.
module tb_max7219_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_req = 1'b0;
  logic [7:0]  cfg_decode = 8'h00;
  logic [3:0]  cfg_intensity = 4'h0;
  logic        cfg_ack;
  logic        upd_req = 1'b0;
  logic [31:0] upd_num = 32'h0;
  logic [2:0]  upd_dp = 3'd0;
  logic        upd_ack;
  logic [7:0]  ser_addr;
  logic [7:0]  ser_data;
  logic        ser_start;
  logic        ser_busy;
  logic        init_done;
  logic        busy;

  logic        hold_busy = 1'b0;
  logic [2:0]  ser_cnt = 3'd0;

  int errors = 0;
  int checks = 0;
  int cfg_ack_cnt = 0;
  int upd_ack_cnt = 0;
  logic [15:0] wr_q [$];

  max7219_scheduler dut (
    .clock(clock), .reset(reset),
    .cfg_req(cfg_req), .cfg_decode(cfg_decode), .cfg_intensity(cfg_intensity), .cfg_ack(cfg_ack),
    .upd_req(upd_req), .upd_num(upd_num), .upd_dp(upd_dp), .upd_ack(upd_ack),
    .ser_addr(ser_addr), .ser_data(ser_data), .ser_start(ser_start), .ser_busy(ser_busy),
    .init_done(init_done), .busy(busy)
  );

  always #5 clock = ~clock;

  // Serializer model: busy for three cycles after each accepted strobe.
  always @(posedge clock) begin
    if (!reset) ser_cnt <= 3'd0;
    else if (ser_start) ser_cnt <= 3'd3;
    else if (ser_cnt != 3'd0) ser_cnt <= ser_cnt - 3'd1;
  end
  assign ser_busy = hold_busy || (ser_cnt != 3'd0);

  // Write and ack monitor, one line per write.
  always @(negedge clock) begin
    if (ser_start) begin
      wr_q.push_back({ser_addr, ser_data});
      $display("write addr=%h data=%h", ser_addr, ser_data);
    end
    if (cfg_ack) cfg_ack_cnt++;
    if (upd_ack) upd_ack_cnt++;
  end

  function automatic logic [15:0] exp_init(input int i);
    case (i)
      0: return 16'h0F00;
      1: return 16'h0C01;
      2: return 16'h0B07;
      3: return 16'h09FF;
      4: return 16'h0A08;
      default: return {8'(i - 4), 8'h00};
    endcase
  endfunction

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clock);
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_init(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clock);
      if (init_done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_ack(input bit is_cfg, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clock);
      if (is_cfg ? cfg_ack : upd_ack) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (ser_start !== 1'b0) begin errors++; $display("FAIL rst_start got %b want 0", ser_start); end
    checks++; if (ser_addr !== 8'h00) begin errors++; $display("FAIL rst_addr got %h want 00", ser_addr); end
    checks++; if (ser_data !== 8'h00) begin errors++; $display("FAIL rst_data got %h want 00", ser_data); end
    checks++; if ({cfg_ack, upd_ack} !== 2'b00) begin errors++; $display("FAIL rst_acks got %b want 00", {cfg_ack, upd_ack}); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL rst_init_done got %b want 0", init_done); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy got %b want 1", busy); end
    wr_q.delete();
    reset = 1'b1;
    @(negedge clock);
    checks++; if (ser_start !== 1'b1 || ser_addr !== 8'h0F) begin errors++; $display("FAIL first_issue got start=%b addr=%h want 1/0F", ser_start, ser_addr); end
    $display("test_reset done");
  endtask

  task automatic test_init();
    bit ok;
    wait_init(ok);
    checks++; if (!ok) begin errors++; $display("FAIL init_timeout got no init_done want 1"); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL init_busy got %b want 0", busy); end
    checks++; if (wr_q.size() != 13) begin errors++; $display("FAIL init_count got %0d want 13", wr_q.size()); end
    for (int i = 0; i < 13; i++) begin
      if (i < wr_q.size()) begin
        checks++;
        if (wr_q[i] !== exp_init(i)) begin errors++; $display("FAIL init_write%0d got %h want %h", i, wr_q[i], exp_init(i)); end
      end
    end
    $display("test_init done");
  endtask

  task automatic test_digit_update();
    bit ok;
    logic [7:0] exp_d [8] = '{8'h01, 8'h02, 8'h03, 8'h84, 8'h05, 8'h06, 8'h07, 8'h08};
    wr_q.delete();
    upd_num = 32'h87654321; upd_dp = 3'd3; upd_req = 1'b1;
    @(negedge clock);
    checks++; if (upd_ack !== 1'b1) begin errors++; $display("FAIL upd_ack_latency got %b want 1", upd_ack); end
    checks++; if (ser_start !== 1'b1) begin errors++; $display("FAIL upd_start_latency got %b want 1", ser_start); end
    upd_req = 1'b0;
    @(negedge clock);
    checks++; if (upd_ack !== 1'b0) begin errors++; $display("FAIL upd_ack_pulse got %b want 0", upd_ack); end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL upd_timeout got busy want idle"); end
    checks++; if (wr_q.size() != 8) begin errors++; $display("FAIL upd_count got %0d want 8", wr_q.size()); end
    for (int i = 0; i < 8; i++) begin
      if (i < wr_q.size()) begin
        checks++;
        if (wr_q[i] !== {8'(i + 1), exp_d[i]}) begin errors++; $display("FAIL upd_write%0d got %h want %h", i, wr_q[i], {8'(i + 1), exp_d[i]}); end
      end
    end
    $display("test_digit_update done");
  endtask

  task automatic test_simultaneous();
    bit ok;
    logic [15:0] exp_w [12] = '{16'h095A, 16'h0A03,
                                16'h0188, 16'h0207, 16'h0306, 16'h0405, 16'h0504, 16'h0603, 16'h0702, 16'h0801,
                                16'h09A5, 16'h0A0C};
    wr_q.delete();
    cfg_decode = 8'h5A; cfg_intensity = 4'h3;
    upd_num = 32'h12345678; upd_dp = 3'd0;
    cfg_req = 1'b1; upd_req = 1'b1;
    wait_ack(1'b1, ok);
    checks++; if (!ok || upd_ack !== 1'b0) begin errors++; $display("FAIL tie1_cfg_first got ok=%b upd_ack=%b want 1/0", ok, upd_ack); end
    // A fresh cfg request is raised at once, so the end of the cfg burst is a second tie.
    cfg_decode = 8'hA5; cfg_intensity = 4'hC;
    wait_ack(1'b0, ok);
    checks++; if (!ok || cfg_ack !== 1'b0) begin errors++; $display("FAIL tie2_upd_first got ok=%b cfg_ack=%b want 1/0", ok, cfg_ack); end
    upd_req = 1'b0;
    wait_ack(1'b1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL tie_cfg2_timeout got no ack want ack"); end
    cfg_req = 1'b0;
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL tie_idle_timeout got busy want idle"); end
    checks++; if (wr_q.size() != 12) begin errors++; $display("FAIL tie_count got %0d want 12", wr_q.size()); end
    for (int i = 0; i < 12; i++) begin
      if (i < wr_q.size()) begin
        checks++;
        if (wr_q[i] !== exp_w[i]) begin errors++; $display("FAIL tie_write%0d got %h want %h", i, wr_q[i], exp_w[i]); end
      end
    end
    $display("test_simultaneous done");
  endtask

  task automatic test_busy_hold();
    bit ok;
    int early = 0;
    wr_q.delete();
    hold_busy = 1'b1;
    cfg_decode = 8'h33; cfg_intensity = 4'h1; cfg_req = 1'b1;
    @(negedge clock);
    checks++; if (cfg_ack !== 1'b1) begin errors++; $display("FAIL hold_ack got %b want 1", cfg_ack); end
    cfg_req = 1'b0;
    if (ser_start !== 1'b0) early++;
    repeat (4) begin
      @(negedge clock);
      if (ser_start !== 1'b0) early++;
    end
    checks++; if (early != 0) begin errors++; $display("FAIL hold_no_start got %0d strobes want 0", early); end
    hold_busy = 1'b0;
    #1;
    checks++; if (ser_start !== 1'b1) begin errors++; $display("FAIL hold_release_start got %b want 1", ser_start); end
    @(negedge clock);
    checks++; if (ser_start !== 1'b0) begin errors++; $display("FAIL hold_single_pulse got %b want 0", ser_start); end
    wait_idle(ok);
    checks++; if (!ok || wr_q.size() != 2) begin errors++; $display("FAIL hold_count got %0d want 2", wr_q.size()); end
    if (wr_q.size() == 2) begin
      checks++; if (wr_q[0] !== 16'h0933 || wr_q[1] !== 16'h0A01) begin errors++; $display("FAIL hold_writes got %h %h want 0933 0A01", wr_q[0], wr_q[1]); end
    end
    $display("test_busy_hold done");
  endtask

  task automatic test_req_during_init();
    bit ok;
    reset = 1'b0;
    cfg_decode = 8'h0F; cfg_intensity = 4'h6; cfg_req = 1'b1;
    repeat (2) @(negedge clock);
    wr_q.delete(); cfg_ack_cnt = 0;
    reset = 1'b1;
    wait_init(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rdi_timeout got no init_done want 1"); end
    checks++; if (cfg_ack_cnt != 0 || cfg_ack !== 1'b0) begin errors++; $display("FAIL rdi_early_ack got %0d acks want 0", cfg_ack_cnt); end
    checks++; if (wr_q.size() != 13) begin errors++; $display("FAIL rdi_init_count got %0d want 13", wr_q.size()); end
    @(negedge clock);
    checks++; if (cfg_ack !== 1'b1) begin errors++; $display("FAIL rdi_ack_first_idle got %b want 1", cfg_ack); end
    cfg_req = 1'b0;
    wait_idle(ok);
    checks++; if (!ok || wr_q.size() != 15) begin errors++; $display("FAIL rdi_total got %0d want 15", wr_q.size()); end
    if (wr_q.size() == 15) begin
      checks++; if (wr_q[13] !== 16'h090F || wr_q[14] !== 16'h0A06) begin errors++; $display("FAIL rdi_cfg_writes got %h %h want 090F 0A06", wr_q[13], wr_q[14]); end
    end
    $display("test_req_during_init done");
  endtask

  task automatic test_reset_mid();
    bit ok;
    wr_q.delete(); upd_ack_cnt = 0;
    upd_num = 32'h11111111; upd_dp = 3'd7; upd_req = 1'b1;
    wait_ack(1'b0, ok);
    upd_req = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL mid_ack_timeout got no ack want ack"); end
    ok = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clock);
      if (ser_start && ser_addr == 8'h04) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL mid_4th_timeout got no 4th write want write"); end
    reset = 1'b0;
    @(negedge clock);
    checks++; if ({ser_start, cfg_ack, upd_ack, init_done} !== 4'b0000) begin errors++; $display("FAIL mid_rst_flags got %b want 0000", {ser_start, cfg_ack, upd_ack, init_done}); end
    checks++; if (ser_addr !== 8'h00 || ser_data !== 8'h00 || busy !== 1'b1) begin errors++; $display("FAIL mid_rst_bus got addr=%h data=%h busy=%b want 00/00/1", ser_addr, ser_data, busy); end
    wr_q.delete(); upd_ack_cnt = 0;
    @(negedge clock);
    reset = 1'b1;
    wait_init(ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_init_timeout got no init_done want 1"); end
    checks++; if (wr_q.size() != 13) begin errors++; $display("FAIL mid_init_count got %0d want 13", wr_q.size()); end
    for (int i = 0; i < 13; i++) begin
      if (i < wr_q.size()) begin
        checks++;
        if (wr_q[i] !== exp_init(i)) begin errors++; $display("FAIL mid_init_write%0d got %h want %h", i, wr_q[i], exp_init(i)); end
      end
    end
    repeat (3) @(negedge clock);
    checks++; if (upd_ack_cnt != 0 || busy !== 1'b0) begin errors++; $display("FAIL mid_no_reack got acks=%0d busy=%b want 0/0", upd_ack_cnt, busy); end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_init();
    test_digit_update();
    test_simultaneous();
    test_busy_hold();
    test_req_during_init();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
